ins_cache_fill_ctrl: RTL and testbench

INS_CACHE_FILL_CTRL -- requirements
Module: ins_cache_fill_ctrl

---
 rtl/ins_cache_fill_ctrl.sv | 137 +++++++++++++
 tb/tb_ins_cache_fill_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_cache_fill_ctrl.sv
// Instruction cache fill controller: a single-window instruction cache that is
// refilled from DDR by one burst read whenever a fetch falls outside the window.
module ins_cache_fill_ctrl #(
  parameter int ISA_DEPTH      = 128,
  parameter int ISA_WIDTH      = 30,
  parameter int ADDR_WIDTH_MEM = 16,
  parameter int DDR_ADDR_WIDTH = 28
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ins_req,
  input  logic [ADDR_WIDTH_MEM-1:0] addr_ins,
  output logic                      ins_valid,
  output logic [ISA_WIDTH-1:0]      ins_out,
  output logic                      ins_err,
  output logic                      busy,
  output logic                      rd_burst_req,
  output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
  output logic [9:0]                rd_burst_len,
  input  logic                      rd_burst_data_valid,
  input  logic [ISA_WIDTH-1:0]      rd_burst_data,
  output logic [ADDR_WIDTH_MEM-1:0] tag_ins,
  output logic [9:0]                load_times
);

  localparam int IDX_W = (ISA_DEPTH > 1) ? $clog2(ISA_DEPTH) : 1;
  localparam int CMP_W = ADDR_WIDTH_MEM + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_FILL,
    S_RESP
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH_MEM-1:0] addr_q;
  logic                      tag_valid_q;
  logic [IDX_W-1:0]          cnt_q;
  logic [ISA_WIDTH-1:0]      cache [ISA_DEPTH];

  logic [CMP_W-1:0] addr_ext, tag_lo, tag_hi;
  logic             hit, illegal, beat_we, last_beat;
  logic [IDX_W-1:0] rd_idx;

  // Window test is done one bit wider so a window near the top of the address
  // space never wraps around and aliases low addresses.
  assign addr_ext  = {1'b0, addr_q};
  assign tag_lo    = {1'b0, tag_ins};
  assign tag_hi    = tag_lo + CMP_W'(ISA_DEPTH);
  assign hit       = tag_valid_q && (addr_ext >= tag_lo) && (addr_ext < tag_hi);
  assign illegal   = addr_q[ADDR_WIDTH_MEM-1];
  assign beat_we   = ((state_q == S_MISS_REQ) || (state_q == S_FILL)) && rd_burst_data_valid;
  assign last_beat = beat_we && (cnt_q == IDX_W'(ISA_DEPTH - 1));
  assign rd_idx    = IDX_W'(addr_q - tag_ins);

  assign busy          = (state_q != S_IDLE);
  assign rd_burst_req  = (state_q == S_MISS_REQ);
  assign rd_burst_addr = rd_burst_req ? (DDR_ADDR_WIDTH'(addr_q) << 3) : '0;
  assign rd_burst_len  = 10'(ISA_DEPTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (ins_req) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (illegal)  state_d = S_IDLE;
        else if (hit) state_d = S_RESP;
        else          state_d = S_MISS_REQ;
      end
      S_MISS_REQ: if (beat_we) state_d = last_beat ? S_RESP : S_FILL;
      S_FILL:     if (last_beat) state_d = S_RESP;
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q      <= '0;
      tag_ins     <= '0;
      tag_valid_q <= 1'b0;
      cnt_q       <= '0;
      load_times  <= '0;
      ins_out     <= '0;
      ins_valid   <= 1'b0;
      ins_err     <= 1'b0;
    end else begin
      ins_valid <= 1'b0;
      ins_err   <= 1'b0;
      unique case (state_q)
        S_IDLE: if (ins_req) addr_q <= addr_ins;
        S_LOOKUP: begin
          if (illegal) begin
            ins_err <= 1'b1;
          end else if (!hit) begin
            tag_ins     <= addr_q;
            tag_valid_q <= 1'b0;
            cnt_q       <= '0;
          end
        end
        S_MISS_REQ, S_FILL: begin
          if (beat_we) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_beat) begin
              tag_valid_q <= 1'b1;
              if (load_times != 10'h3FF) load_times <= load_times + 10'd1;
            end
          end
        end
        S_RESP: begin
          // After a fill tag_ins equals the fetch address, so rd_idx is 0.
          ins_valid <= 1'b1;
          ins_out   <= cache[rd_idx];
        end
        default: ;
      endcase
    end
  end

  // NOTE: the cache array has no reset; tag_valid gates every use of its
  // contents, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (beat_we) cache[cnt_q] <= rd_burst_data;
  end

endmodule

// File: tb/tb_ins_cache_fill_ctrl.sv
// Directed bench for ins_cache_fill_ctrl: a small DDR responder plus
// hand-computed expectations for fill, hit, miss, error and reset scenarios.
module tb_ins_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ins_req;
  logic [15:0] addr_ins;
  logic        ins_valid;
  logic [29:0] ins_out;
  logic        ins_err;
  logic        busy;
  logic        rd_burst_req;
  logic [27:0] rd_burst_addr;
  logic [9:0]  rd_burst_len;
  logic        rd_burst_data_valid;
  logic [29:0] rd_burst_data;
  logic [15:0] tag_ins;
  logic [9:0]  load_times;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ins_cache_fill_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .ins_req             (ins_req),
    .addr_ins            (addr_ins),
    .ins_valid           (ins_valid),
    .ins_out             (ins_out),
    .ins_err             (ins_err),
    .busy                (busy),
    .rd_burst_req        (rd_burst_req),
    .rd_burst_addr       (rd_burst_addr),
    .rd_burst_len        (rd_burst_len),
    .rd_burst_data_valid (rd_burst_data_valid),
    .rd_burst_data       (rd_burst_data),
    .tag_ins             (tag_ins),
    .load_times          (load_times)
  );

  // Request is raised just after one edge and sampled by the next; the task
  // returns 1 time unit after that sampling edge.
  task automatic send_req(input logic [15:0] a);
    @(posedge clk); #1;
    ins_req  = 1'b1;
    addr_ins = a;
    @(posedge clk); #1;
    ins_req  = 1'b0;
  endtask

  task automatic wait_burst(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rd_burst_req) seen = 1'b1;
    end
  endtask

  // Drives n beats with data base+i, starting at the current negedge.
  task automatic serve(input int n, input int base, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (i == 1) begin
        tests_run++;
        if (rd_burst_req !== 1'b0) begin
          tests_failed++;
          $display("FAIL burst_req_drop: got %b expected 0", rd_burst_req);
        end
      end
      if (gaps && (i % 16 == 7)) begin
        rd_burst_data_valid = 1'b0;
        @(negedge clk);
      end
      rd_burst_data_valid = 1'b1;
      rd_burst_data       = 30'(base + i);
      @(negedge clk);
    end
    rd_burst_data_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int lat, output bit seen,
                            output bit burst_seen);
    seen = 1'b0; lat = 0; burst_seen = 1'b0;
    while (!seen && lat < budget) begin
      @(negedge clk);
      lat++;
      if (rd_burst_req) burst_seen = 1'b1;
      if (ins_valid) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; ins_req = 1'b0; addr_ins = '0;
    rd_burst_data_valid = 1'b0; rd_burst_data = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, ins_valid, ins_err, rd_burst_req} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, ins_valid, ins_err, rd_burst_req});
    end
    tests_run++;
    if ({tag_ins, load_times, ins_out} !== '0) begin
      tests_failed++;
      $display("FAIL reset_regs: tag %h load %0d out %h expected all 0", tag_ins, load_times, ins_out);
    end
    rst = 1'b1;
  endtask

  // Miss on 0x0010, 128 beats with data i.
  task automatic test_miss_fill();
    bit seen, bseen; int lat;
    send_req(16'h0010);
    wait_burst(seen);
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL fill_burst_req: got none expected rd_burst_req");
    end
    tests_run++;
    if (rd_burst_addr !== 28'h80 || rd_burst_len !== 10'd128) begin
      tests_failed++;
      $display("FAIL fill_burst_cmd: got addr %h len %0d expected 80 128", rd_burst_addr, rd_burst_len);
    end
    serve(128, 0, 1'b1);
    wait_valid(10, lat, seen, bseen);
    tests_run++;
    if (!seen || ins_out !== 30'd0) begin
      tests_failed++;
      $display("FAIL fill_resp: got valid %b out %0d expected 1 0", seen, ins_out);
    end
    tests_run++;
    if (tag_ins !== 16'h0010 || load_times !== 10'd1) begin
      tests_failed++;
      $display("FAIL fill_state: got tag %h load %0d expected 0010 1", tag_ins, load_times);
    end
    @(negedge clk);
    tests_run++;
    if (ins_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_pulse: got valid %b busy %b expected 0 0", ins_valid, busy);
    end
  endtask

  // Last word of the window: 0x008F -> index 127.
  task automatic test_hit();
    bit seen, bseen; int lat;
    send_req(16'h008F);
    wait_valid(10, lat, seen, bseen);
    tests_run++;
    if (!seen || lat !== 3) begin
      tests_failed++;
      $display("FAIL hit_latency: got valid %b after %0d cycles expected 1 after 3", seen, lat);
    end
    tests_run++;
    if (ins_out !== 30'd127 || bseen !== 1'b0) begin
      tests_failed++;
      $display("FAIL hit_data: got out %0d burst %b expected 127 0", ins_out, bseen);
    end
  endtask

  // One past the window: 0x0090 must refetch.
  task automatic test_miss_next_window();
    bit seen, bseen; int lat;
    send_req(16'h0090);
    wait_burst(seen);
    tests_run++;
    if (!seen || rd_burst_addr !== 28'h480) begin
      tests_failed++;
      $display("FAIL next_burst: got req %b addr %h expected 1 480", seen, rd_burst_addr);
    end
    serve(128, 1000, 1'b0);
    wait_valid(10, lat, seen, bseen);
    tests_run++;
    if (!seen || ins_out !== 30'd1000 || load_times !== 10'd2 || tag_ins !== 16'h0090) begin
      tests_failed++;
      $display("FAIL next_resp: got valid %b out %0d load %0d tag %h expected 1 1000 2 0090",
               seen, ins_out, load_times, tag_ins);
    end
  endtask

  task automatic test_illegal();
    send_req(16'h8000);
    @(negedge clk);
    tests_run++;
    if (ins_err !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_lookup: got err %b busy %b expected 0 1", ins_err, busy);
    end
    @(negedge clk);
    tests_run++;
    if (ins_err !== 1'b1 || busy !== 1'b0 || rd_burst_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_pulse: got err %b busy %b req %b expected 1 0 0", ins_err, busy, rd_burst_req);
    end
    @(negedge clk);
    tests_run++;
    if (ins_err !== 1'b0 || rd_burst_req !== 1'b0 || ins_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_clear: got err %b req %b valid %b expected 0 0 0", ins_err, rd_burst_req, ins_valid);
    end
  endtask

  task automatic test_reset_mid_fill();
    bit seen, bseen; int lat;
    send_req(16'h0010);
    wait_burst(seen);
    serve(40, 2000, 1'b0);
    rst = 1'b0;
    #2;
    tests_run++;
    if ({busy, rd_burst_req, ins_valid, tag_ins, load_times, ins_out} !== '0) begin
      tests_failed++;
      $display("FAIL midfill_reset: got busy %b req %b tag %h load %0d out %h expected all 0",
               busy, rd_burst_req, tag_ins, load_times, ins_out);
    end
    @(negedge clk);
    rst = 1'b1;
    send_req(16'h0010);
    wait_burst(seen);
    tests_run++;
    if (!seen || rd_burst_addr !== 28'h80) begin
      tests_failed++;
      $display("FAIL refetch_req: got req %b addr %h expected 1 80", seen, rd_burst_addr);
    end
    serve(128, 5, 1'b1);
    wait_valid(10, lat, seen, bseen);
    tests_run++;
    if (!seen || ins_out !== 30'd5 || load_times !== 10'd1) begin
      tests_failed++;
      $display("FAIL refetch_resp: got valid %b out %0d load %0d expected 1 5 1", seen, ins_out, load_times);
    end
  endtask

  // Stray beats in IDLE must not overwrite the cache.
  task automatic test_ignore_idle_beats();
    bit seen, bseen; int lat;
    @(negedge clk);
    rd_burst_data_valid = 1'b1;
    rd_burst_data       = 30'h3FFF_FFFF;
    repeat (4) @(negedge clk);
    rd_burst_data_valid = 1'b0;
    send_req(16'h0010);
    wait_valid(10, lat, seen, bseen);
    tests_run++;
    if (!seen || ins_out !== 30'd5 || bseen !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_beats: got valid %b out %h burst %b expected 1 5 0", seen, ins_out, bseen);
    end
  endtask

  // Request held high across LOOKUP and RESP must be ignored.
  task automatic test_back_to_back();
    int valids, bursts;
    send_req(16'h0011);
    ins_req  = 1'b1;
    addr_ins = 16'h0200;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ins_req  = 1'b0;
    valids = 0; bursts = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ins_valid) valids++;
      if (rd_burst_req) bursts++;
    end
    tests_run++;
    if (valids !== 1 || bursts !== 0) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d valids %0d bursts expected 1 0", valids, bursts);
    end
    tests_run++;
    if (ins_out !== 30'd6 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_data: got out %0d busy %b expected 6 0", ins_out, busy);
    end
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_hit();
    test_miss_next_window();
    test_illegal();
    test_reset_mid_fill();
    test_ignore_idle_beats();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
